tone_recorder: RTL and testbench
================================

TONE_RECORDER -- requirements
Module: tone_recorder

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the RAM write-address width.
REQ-002 Parameter DATA_W, default 20, SHALL set the stored half-period word width.
REQ-003 Parameter NOTE_TICKS, default 9200000, SHALL set the CLOCK_50 cycles per recorded note slot.
REQ-004 Parameter LAST_ADDR, default 193, SHALL set the final address written per recording.
REQ-005 Parameter THRESH, default 1000000, SHALL set the signed hysteresis magnitude for zero-crossing detection.
REQ-006 CLOCK_50  in  1  system clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse requesting a new recording.
REQ-009 audio_in_available  in  1  audio controller has a sample pair ready.
REQ-010 left_channel_audio_in  in  32  signed microphone sample.
REQ-011 read_audio_in  out  1  consume strobe to the audio controller.
REQ-012 wr_addr  out  ADDR_W  tone RAM write address.
REQ-013 wr_data  out  DATA_W  half-period (CLOCK_50 cycles) to store; 0 = silence.
REQ-014 wr_en  out  1  one-cycle RAM write strobe.
REQ-015 busy  out  1  high in RECORD.
REQ-016 done  out  1  high in DONE.

Function
REQ-017 read_audio_in SHALL equal audio_in_available combinationally in every state, so the input FIFO never overflows; a sample is processed on each cycle read_audio_in is high.
REQ-018 FSM states SHALL be IDLE, RECORD, DONE; start in IDLE or DONE -> RECORD with wr_addr=0, note counter=0, half counter=0, valid flag=0; start in RECORD SHALL be ignored.
REQ-019 Polarity register SHALL switch NEG->POS only when sample (signed) > +THRESH and POS->NEG only when sample < -THRESH; each switch is a crossing event; samples within the band change nothing.
REQ-020 Half counter SHALL increment every cycle in RECORD, saturating at 2^DATA_W-1; on a crossing, last_half <= half counter value, half counter <= 0, valid flag <= 1.
REQ-021 Note counter SHALL increment every cycle in RECORD; when it equals NOTE_TICKS-1 it SHALL wrap to 0 and a write SHALL occur on the next cycle.
REQ-022 Write data SHALL be last_half if valid flag set during the slot, else 0; valid flag SHALL clear at the write.
REQ-023 Crossing and slot end in the same cycle: the write SHALL use the newly captured half-period and the valid flag SHALL remain set for the next slot.
REQ-024 After each write wr_addr SHALL increment; the write at wr_addr==LAST_ADDR SHALL move FSM to DONE with wr_addr held at LAST_ADDR.
REQ-025 wr_en SHALL be high for exactly one cycle per slot and never outside RECORD.
REQ-026 Counters SHALL be frozen in IDLE and DONE; polarity tracking continues in all states.

Reset
REQ-027 Reset SHALL force IDLE, polarity=NEG, wr_addr=0, wr_data=0, wr_en=0, busy=0, done=0, all counters and valid flag 0.
REQ-028 Reset mid-recording SHALL abort without a further write; RAM contents are not cleared.

Structure
REQ-029 Shared package SHALL hold FSM state encoding and defaults for NOTE_TICKS, LAST_ADDR, THRESH, matching the playback block.
REQ-030 Zero-crossing detector (polarity, hysteresis, half counter) SHALL be sub-module zc_period_meter.

Verification (NOTE_TICKS=1000, LAST_ADDR=3, THRESH=100)
REQ-031 Reset, start, square input +/-500 toggling every 200 cycles -> 4 writes, addr 0..3, wr_data=200 (+/-1), then done=1, busy=0.
REQ-032 Constant 0 input after start -> 4 writes of wr_data=0, done at slot 4.
REQ-033 Samples alternating +/-50 (inside band) -> no crossings, all writes 0.
REQ-034 Crossing forced on slot-end cycle -> that write carries new period; next slot writes same value without new crossing.
REQ-035 Reset asserted during slot 2 -> no wr_en afterwards, state IDLE; start in RECORD ignored (wr_addr not reset).
REQ-036 start in DONE -> new recording from addr 0; audio_in_available pulses always mirrored on read_audio_in.

Source files
------------

// File: rtl/tone_recorder_pkg.sv
// rtl/tone_recorder_pkg.sv - shared FSM encoding and default tuning for tone record/playback
package tone_recorder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_DONE   = 2'd2
   } rec_state_t;

   localparam int DEF_NOTE_TICKS = 9200000;
   localparam int DEF_LAST_ADDR  = 193;
   localparam int DEF_THRESH     = 1000000;

endpackage

// File: rtl/tone_recorder_zc_period_meter.sv
// rtl/tone_recorder_zc_period_meter.sv - hysteresis zero-crossing detector with half-period counter
module zc_period_meter
   import tone_recorder_pkg::*;
#(
   parameter int DATA_W = 20,
   parameter int THRESH = DEF_THRESH
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [31:0]       sample,
   input  logic              count_en,
   input  logic              clear,
   output logic              crossing,
   output logic [DATA_W-1:0] half_cnt
);

   localparam logic signed [31:0] POS_LIM = 32'(THRESH);
   localparam logic signed [31:0] NEG_LIM = -32'(THRESH);
   localparam logic [DATA_W-1:0]  HALF_MAX = '1;

   logic pos;

   // Polarity only flips once the sample leaves the dead band on the far side.
   always_comb begin
      crossing = 1'b0;
      if (sample_valid) begin
         if (!pos && ($signed(sample) > POS_LIM))
            crossing = 1'b1;
         else if (pos && ($signed(sample) < NEG_LIM))
            crossing = 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         pos      <= 1'b0;
         half_cnt <= '0;
      end else begin
         if (crossing)
            pos <= ~pos;
         if (clear)
            half_cnt <= '0;
         else if (count_en) begin
            if (crossing)
               half_cnt <= '0;
            else if (half_cnt != HALF_MAX)
               half_cnt <= half_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tone_recorder.sv
// rtl/tone_recorder.sv - records one measured half-period per note slot into tone RAM
module tone_recorder
   import tone_recorder_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 20,
   parameter int NOTE_TICKS = DEF_NOTE_TICKS,
   parameter int LAST_ADDR  = DEF_LAST_ADDR,
   parameter int THRESH     = DEF_THRESH
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   input  logic              audio_in_available,
   input  logic [31:0]       left_channel_audio_in,
   output logic              read_audio_in,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_en,
   output logic              busy,
   output logic              done
);

   localparam int NOTE_W = $clog2(NOTE_TICKS + 1);
   localparam logic [NOTE_W-1:0] NOTE_END = NOTE_W'(NOTE_TICKS - 1);
   localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(LAST_ADDR);

   rec_state_t        state;
   logic [NOTE_W-1:0] note_cnt;
   logic [DATA_W-1:0] half_cnt;
   logic [DATA_W-1:0] last_half;
   logic              valid;
   logic              crossing;
   logic              in_record;
   logic              start_rec;
   logic              cross_rec;

   // Draining every offered sample keeps the codec FIFO from ever overflowing.
   assign read_audio_in = audio_in_available;
   assign in_record     = (state == ST_RECORD);
   assign start_rec     = start && !in_record;
   assign cross_rec     = crossing && in_record;

   zc_period_meter #(
      .DATA_W (DATA_W),
      .THRESH (THRESH)
   ) u_zc (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .sample_valid (read_audio_in),
      .sample       (left_channel_audio_in),
      .count_en     (in_record),
      .clear        (start_rec),
      .crossing     (crossing),
      .half_cnt     (half_cnt)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state     <= ST_IDLE;
         note_cnt  <= '0;
         wr_addr   <= '0;
         wr_data   <= '0;
         wr_en     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         last_half <= '0;
         valid     <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state    <= ST_RECORD;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  wr_addr  <= '0;
                  note_cnt <= '0;
                  valid    <= 1'b0;
               end
            end
            ST_RECORD: begin
               if (cross_rec) begin
                  last_half <= half_cnt;
                  valid     <= 1'b1;
               end
               // A crossing on the slot's last cycle wins over the stale capture.
               if (note_cnt == NOTE_END) begin
                  note_cnt <= '0;
                  wr_en    <= 1'b1;
                  wr_data  <= cross_rec ? half_cnt : (valid ? last_half : '0);
                  if (!cross_rec)
                     valid <= 1'b0;
               end else begin
                  note_cnt <= note_cnt + 1'b1;
               end
               if (wr_en) begin
                  if (wr_addr == ADDR_END) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     wr_addr <= wr_addr + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tone_recorder.sv
// tb/tb_tone_recorder.sv - directed table-driven bench for tone_recorder
module tb_tone_recorder;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 20;
   localparam int NT     = 1000;
   localparam int LA     = 3;
   localparam int TH     = 100;

   logic              CLOCK_50 = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              audio_in_available = 1'b1;
   logic [31:0]       sample = '0;
   logic              read_audio_in;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_en;
   logic              busy;
   logic              done;

   int n_pass = 0;
   int n_total = 0;
   int wq_addr[$];
   int wq_data[$];

   typedef struct {
      string name;
      int    mode;
      int    amp;
      int    period;
      int    exp_data;
      int    tol;
   } vec_t;

   vec_t vecs[5];

   tone_recorder #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .NOTE_TICKS (NT),
      .LAST_ADDR  (LA),
      .THRESH     (TH)
   ) dut (
      .CLOCK_50              (CLOCK_50),
      .reset                 (reset),
      .start                 (start),
      .audio_in_available    (audio_in_available),
      .left_channel_audio_in (sample),
      .read_audio_in         (read_audio_in),
      .wr_addr               (wr_addr),
      .wr_data               (wr_data),
      .wr_en                 (wr_en),
      .busy                  (busy),
      .done                  (done)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
      n_total++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
   endtask

   always @(negedge CLOCK_50) begin
      if (wr_en) begin
         wq_addr.push_back(int'(wr_addr));
         wq_data.push_back(int'(wr_data));
         check("wr_en_only_in_record", busy, 1);
      end
   end

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_mirror(input string name);
      audio_in_available = 1'b0;
      #1;
      check({name, "_mirror0"}, read_audio_in, 0);
      audio_in_available = 1'b1;
      #1;
      check({name, "_mirror1"}, read_audio_in, 1);
   endtask

   function automatic int pattern(input vec_t v, input int c);
      case (v.mode)
         0: return v.amp;
         1: return ((c / v.period) % 2 == 0) ? v.amp : -v.amp;
         default: return (c % 2 == 0) ? v.amp : -v.amp;
      endcase
   endfunction

   initial begin
      #(20 * 90000);
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{"square500_p200", 1, 500, 200, 199, 1};
      vecs[1] = '{"const0",         0, 0,   200, 0,   0};
      vecs[2] = '{"alt50_inband",   2, 50,  1,   0,   0};
      vecs[3] = '{"square101_p250", 1, 101, 250, 249, 1};
      vecs[4] = '{"square100_edge", 1, 100, 200, 0,   0};

      do_reset();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check_mirror("idle");

      for (int v = 0; v < 5; v++) begin
         do_reset();
         wq_addr.delete();
         wq_data.delete();
         pulse_start();
         for (int c = 0; c < 4 * NT + 5; c++) begin
            sample = 32'(pattern(vecs[v], c));
            tick();
         end
         check({vecs[v].name, "_nwrites"}, wq_addr.size(), 4);
         for (int i = 0; i < 4; i++) begin
            if (i < wq_addr.size()) begin
               check({vecs[v].name, "_addr"}, wq_addr[i], i);
               check_rng({vecs[v].name, "_data"}, wq_data[i],
                         vecs[v].exp_data - vecs[v].tol, vecs[v].exp_data + vecs[v].tol);
            end
         end
         check({vecs[v].name, "_done"}, done, 1);
         check({vecs[v].name, "_busy"}, busy, 0);
         check({vecs[v].name, "_addr_held"}, wr_addr, LA);
      end
      check_mirror("done");

      // Crossing exactly on the slot's final cycle
      do_reset();
      pulse_start();
      for (int c = 0; c < NT - 1; c++) tick();
      sample = 32'(500);
      tick();
      check("slotend_wr_en0", wr_en, 1);
      check("slotend_data0", wr_data, NT - 1);
      check("slotend_addr0", wr_addr, 0);
      for (int c = 0; c < NT; c++) tick();
      check("slotend_wr_en1", wr_en, 1);
      check("slotend_data1", wr_data, NT - 1);
      check("slotend_addr1", wr_addr, 1);
      for (int c = 0; c < NT; c++) tick();
      check("slotend_data2", wr_data, 0);
      check("slotend_addr2", wr_addr, 2);

      // Start ignored mid-recording, then reset aborts
      do_reset();
      wq_addr.delete();
      wq_data.delete();
      pulse_start();
      for (int c = 0; c < 1199; c++) tick();
      pulse_start();
      check_mirror("record");
      for (int c = 1200; c < 2500; c++) tick();
      check("abort_busy_before", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3000; c++) tick();
      check("abort_nwrites", wq_addr.size(), 2);
      if (wq_addr.size() >= 2) check("ignored_start_addr1", wq_addr[1], 1);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_wr_addr", wr_addr, 0);

      // Restart from DONE
      do_reset();
      pulse_start();
      for (int c = 0; c < 4 * NT + 5; c++) tick();
      check("restart_pre_done", done, 1);
      wq_addr.delete();
      wq_data.delete();
      pulse_start();
      check("restart_busy", busy, 1);
      check("restart_done", done, 0);
      check("restart_addr", wr_addr, 0);
      for (int c = 0; c < NT + 1; c++) tick();
      check("restart_nwrites", wq_addr.size(), 1);
      if (wq_addr.size() >= 1) check("restart_first_addr", wq_addr[0], 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
